// File: rtl/fir_tap_loader.sv
// fir_tap_loader: double-buffered coefficient store for the runtime-loadable
// FIR. Host writes land in the shadow bank. A load swaps banks and shifts the
// new active bank into the filter tap chain, highest index first, while the
// sample strobe to the filter is held off and dropped samples are counted.
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | filter running; waiting for i_load or a pending request
// LOAD   | one tap per cycle on o_tap/o_tap_wr, index N-1 down to 0
// SETTLE | chain written; SETTLE_CYC quiet cycles before o_done
module fir_tap_loader #(
  parameter int N          = 16,
  parameter int TW         = 12,
  parameter int AW         = $clog2(N),
  parameter int SETTLE_CYC = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_coef_wr,
  input  logic [AW-1:0] i_coef_addr,
  input  logic [TW-1:0] i_coef_data,
  input  logic          i_load,
  output logic          o_busy,
  output logic          o_done,
  output logic          o_active_bank,
  output logic          o_tap_wr,
  output logic [TW-1:0] o_tap,
  input  logic          i_sample_stb,
  output logic          o_sample_stb,
  output logic [7:0]    o_drop_cnt
);

  // IW indexes the N-deep banks; AW may be wider so that out-of-range
  // host addresses can be seen and rejected.
  localparam int              IW          = (N > 1) ? $clog2(N) : 1;
  localparam int              SW          = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [AW:0]     N_EXT       = (AW+1)'(N);
  localparam logic [IW-1:0]   IDX_LAST    = IW'(N - 1);
  localparam logic [SW-1:0]   SETTLE_LAST = SW'(SETTLE_CYC - 1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SETTLE} state_t;

  state_t          state_q, state_d;
  logic            active_q, active_d;
  logic            pending_q, pending_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [SW-1:0]   settle_q, settle_d;
  logic            tap_wr_q, tap_wr_d;
  logic [TW-1:0]   tap_q, tap_d;
  logic            done_q, done_d;
  logic [7:0]      drop_q, drop_d;

  logic [TW-1:0]   mem_q [2][N];
  logic            coef_we;
  logic [IW-1:0]   coef_idx;
  logic            busy;

  assign busy          = (state_q != S_IDLE);
  assign o_busy        = busy;
  assign o_done        = done_q;
  assign o_active_bank = active_q;
  assign o_tap_wr      = tap_wr_q;
  assign o_tap         = tap_q;
  assign o_drop_cnt    = drop_q;
  assign o_sample_stb  = i_sample_stb & ~busy;

  // Host write qualification: drop addresses at or above N.
  always_comb begin
    coef_we  = i_coef_wr && ({1'b0, i_coef_addr} < N_EXT);
    coef_idx = i_coef_addr[IW-1:0];
  end

  // Coefficient RAM; shadow bank is always the one not being fed to the filter.
  always_ff @(posedge clk) begin
    if (coef_we) begin
      mem_q[~active_q][coef_idx] <= i_coef_data;
    end
  end

  // Next-state, tap streaming and pending-request bookkeeping.
  always_comb begin
    state_d   = state_q;
    active_d  = active_q;
    pending_d = pending_q;
    idx_d     = idx_q;
    settle_d  = settle_q;
    tap_wr_d  = 1'b0;
    tap_d     = tap_q;
    done_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (i_load || pending_q) begin
          state_d   = S_LOAD;
          active_d  = ~active_q;
          pending_d = 1'b0;
          idx_d     = IDX_LAST;
          tap_wr_d  = 1'b1;
          tap_d     = mem_q[~active_q][IDX_LAST];
        end
      end
      S_LOAD: begin
        if (i_load) pending_d = 1'b1;
        if (idx_q == '0) begin
          if (SETTLE_CYC == 0) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else begin
            state_d  = S_SETTLE;
            settle_d = SETTLE_LAST;
          end
        end else begin
          idx_d    = idx_q - 1'b1;
          tap_wr_d = 1'b1;
          tap_d    = mem_q[active_q][idx_q - 1'b1];
        end
      end
      S_SETTLE: begin
        if (i_load) pending_d = 1'b1;
        if (settle_q == '0) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end else begin
          settle_d = settle_q - 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Dropped-sample counter, saturating; only reset clears it.
  always_comb begin
    drop_d = drop_q;
    if (i_sample_stb && busy && (drop_q != 8'hFF)) begin
      drop_d = drop_q + 8'd1;
    end
  end

  // Control and output registers; reset aborts any load in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      active_q  <= 1'b0;
      pending_q <= 1'b0;
      idx_q     <= '0;
      settle_q  <= '0;
      tap_wr_q  <= 1'b0;
      tap_q     <= '0;
      done_q    <= 1'b0;
      drop_q    <= 8'd0;
    end else begin
      state_q   <= state_d;
      active_q  <= active_d;
      pending_q <= pending_d;
      idx_q     <= idx_d;
      settle_q  <= settle_d;
      tap_wr_q  <= tap_wr_d;
      tap_q     <= tap_d;
      done_q    <= done_d;
      drop_q    <= drop_d;
    end
  end

endmodule

// File: tb/tb_fir_tap_loader.sv
// Bench for fir_tap_loader (N=4, TW=12). Streamed taps are checked against a
// queue of expected values filled from a bench-side copy of the banks.
module tb_fir_tap_loader;

  localparam int N  = 4;
  localparam int TW = 12;

  logic          clk;
  logic          reset;
  logic          coef_wr;
  logic [2:0]    coef_addr;
  logic [TW-1:0] coef_data;
  logic          load;
  logic          sample_in;
  logic          busy, done, act, tap_wr, sample_out;
  logic [TW-1:0] tap;
  logic [7:0]    drop;

  logic          s_load;
  logic          s_busy, s_done, s_act, s_tap_wr, s_sample_out;
  logic [TW-1:0] s_tap;
  logic [7:0]    s_drop;

  fir_tap_loader #(.N(N), .TW(TW), .AW(3), .SETTLE_CYC(2)) dut (
    .clk(clk), .reset(reset),
    .i_coef_wr(coef_wr), .i_coef_addr(coef_addr), .i_coef_data(coef_data),
    .i_load(load), .o_busy(busy), .o_done(done), .o_active_bank(act),
    .o_tap_wr(tap_wr), .o_tap(tap),
    .i_sample_stb(sample_in), .o_sample_stb(sample_out), .o_drop_cnt(drop)
  );

  fir_tap_loader #(.N(N), .TW(TW), .SETTLE_CYC(400)) dut_sat (
    .clk(clk), .reset(reset),
    .i_coef_wr(coef_wr), .i_coef_addr(coef_addr[1:0]), .i_coef_data(coef_data),
    .i_load(s_load), .o_busy(s_busy), .o_done(s_done), .o_active_bank(s_act),
    .o_tap_wr(s_tap_wr), .o_tap(s_tap),
    .i_sample_stb(sample_in), .o_sample_stb(s_sample_out), .o_drop_cnt(s_drop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          stb_in;
    logic          busy;
    logic          done;
    logic          tap_wr;
    logic [TW-1:0] tap;
    logic          act;
    logic          stb_out;
  } vec_t;

  vec_t          tbl [8];
  logic [TW-1:0] exp_q [$];
  logic [TW-1:0] model_mem [2][N];
  logic          model_act;
  int            n_cmp = 0;
  int            n_err = 0;

  task automatic chk(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_cmp++;
    if (actual !== expected) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Advance one clock; sample 1ns after the edge and retire a streamed tap.
  task automatic tick();
    @(posedge clk);
    #1;
    if (tap_wr === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_tap_wr: got tap 0x%0h, expected no tap write", tap);
      end else begin
        chk("tap_stream", 32'(tap), 32'(exp_q.pop_front()));
      end
    end
  endtask

  // Record the stream a load will produce and flip the model bank.
  task automatic push_load();
    for (int i = N - 1; i >= 0; i--) exp_q.push_back(model_mem[~model_act][i]);
    model_act = ~model_act;
  endtask

  task automatic host_wr(input int a, input logic [TW-1:0] d);
    coef_wr   = 1'b1;
    coef_addr = 3'(a);
    coef_data = d;
    tick();
    coef_wr   = 1'b0;
    if (a < N) model_mem[~model_act][a] = d;
  endtask

  task automatic wait_done(input string name);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      tick();
      if (done === 1'b1) seen = 1'b1;
    end
    chk(name, 32'(seen), 32'd1);
  endtask

  initial begin
    tbl[0] = '{1'b1, 1'b1, 1'b0, 1'b1, 12'h004, 1'b1, 1'b0};
    tbl[1] = '{1'b1, 1'b1, 1'b0, 1'b1, 12'h003, 1'b1, 1'b0};
    tbl[2] = '{1'b1, 1'b1, 1'b0, 1'b1, 12'h002, 1'b1, 1'b0};
    tbl[3] = '{1'b1, 1'b1, 1'b0, 1'b1, 12'h001, 1'b1, 1'b0};
    tbl[4] = '{1'b1, 1'b1, 1'b0, 1'b0, 12'h001, 1'b1, 1'b0};
    tbl[5] = '{1'b1, 1'b1, 1'b0, 1'b0, 12'h001, 1'b1, 1'b0};
    tbl[6] = '{1'b1, 1'b0, 1'b1, 1'b0, 12'h001, 1'b1, 1'b1};
    tbl[7] = '{1'b0, 1'b0, 1'b0, 1'b0, 12'h001, 1'b1, 1'b0};

    reset = 1'b0; coef_wr = 1'b0; coef_addr = '0; coef_data = '0;
    load = 1'b0; s_load = 1'b0; sample_in = 1'b0; model_act = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
    chk("rst_busy",   32'(busy),   32'd0);
    chk("rst_done",   32'(done),   32'd0);
    chk("rst_act",    32'(act),    32'd0);
    chk("rst_tap_wr", 32'(tap_wr), 32'd0);
    chk("rst_tap",    32'(tap),    32'd0);
    chk("rst_drop",   32'(drop),   32'd0);

    // Basic load with strobes held high across it.
    for (int a = 0; a < N; a++) host_wr(a, TW'(a + 1));
    load = 1'b1;
    sample_in = 1'b1;
    push_load();
    #1;
    chk("pre_load_stb", 32'(sample_out), 32'd1);
    for (int j = 0; j < 8; j++) begin
      sample_in = tbl[j].stb_in;
      tick();
      if (j == 0) load = 1'b0;
      chk($sformatf("row%0d_busy", j),   32'(busy),       32'(tbl[j].busy));
      chk($sformatf("row%0d_done", j),   32'(done),       32'(tbl[j].done));
      chk($sformatf("row%0d_tap_wr", j), 32'(tap_wr),     32'(tbl[j].tap_wr));
      chk($sformatf("row%0d_tap", j),    32'(tap),        32'(tbl[j].tap));
      chk($sformatf("row%0d_act", j),    32'(act),        32'(tbl[j].act));
      chk($sformatf("row%0d_stb", j),    32'(sample_out), 32'(tbl[j].stb_out));
    end
    chk("drop_after_load", 32'(drop), 32'd6);
    sample_in = 1'b0;

    // Pending request during LOAD, another absorbed during SETTLE.
    for (int a = 0; a < N; a++) host_wr(a, TW'((a + 1) * 16));
    load = 1'b1;
    push_load();
    tick();
    load = 1'b0;
    chk("pend_act0", 32'(act), 32'd0);
    tick();
    load = 1'b1;
    push_load();
    tick();
    load = 1'b0;
    tick();
    tick();
    chk("pend_settle", 32'({busy, tap_wr}), 32'b10);
    load = 1'b1;
    tick();
    load = 1'b0;
    tick();
    chk("pend_done",      32'(done), 32'd1);
    chk("pend_done_busy", 32'(busy), 32'd0);
    tick();
    chk("pend_rebusy", 32'(busy), 32'd1);
    chk("pend_act1",   32'(act),  32'd1);
    wait_done("pend_second_done");
    tick();
    tick();
    chk("pend_no_third", 32'(busy), 32'd0);

    // Shadow writes during a load, including one out-of-range address.
    load = 1'b1;
    push_load();
    tick();
    load = 1'b0;
    host_wr(2, 12'hABC);
    host_wr(5, 12'h555);
    wait_done("wr_during_load_done");
    chk("wr_act0", 32'(act), 32'd0);
    load = 1'b1;
    push_load();
    tick();
    load = 1'b0;
    wait_done("abc_load_done");
    chk("abc_act1", 32'(act), 32'd1);

    load = 1'b1;
    push_load();
    tick();
    load = 1'b0;
    wait_done("warm_load_done");

    // Reset in the middle of a load.
    load = 1'b1;
    push_load();
    tick();
    load = 1'b0;
    tick();
    tick();
    chk("pre_abort_act", 32'(act), 32'd1);
    reset = 1'b0;
    #1;
    chk("abort_tap_wr", 32'(tap_wr), 32'd0);
    chk("abort_busy",   32'(busy),   32'd0);
    chk("abort_act",    32'(act),    32'd0);
    exp_q.delete();
    model_act = 1'b0;
    tick();
    reset = 1'b1;
    load = 1'b1;
    push_load();
    tick();
    load = 1'b0;
    wait_done("post_abort_done");
    chk("post_abort_act", 32'(act), 32'd1);

    // Drop counter saturation on the long-settle instance.
    sample_in = 1'b1;
    s_load = 1'b1;
    tick();
    s_load = 1'b0;
    for (int i = 0; i < 300; i++) tick();
    chk("sat_drop",      32'(s_drop),     32'd255);
    chk("sat_busy",      32'(s_busy),     32'd1);
    chk("sat_stb_gated", 32'(s_sample_out), 32'd0);
    chk("idle_stb_pass", 32'(sample_out), 32'd1);
    chk("idle_no_drop",  32'(drop),       32'd0);
    sample_in = 1'b0;

    chk("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
